// File: rtl/a09_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// a09_ctrl_pkg
// Shared definitions for the instruction-fetch control path.
//   state_t      : sequencer state encoding (also driven onto the debug LEDs)
//   PC_SRC_*     : PC mux select codes
//   ADDR_SRC_*   : address mux select codes
//   strobes_t    : bundle of the active-low register/memory strobes
//   WAIT_CNT_W   : width of the memory-wait counter
// No ports (package).
// -----------------------------------------------------------------------------
package a09_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_VECTOR  = 3'd1,
    ST_FETCH   = 3'd2,
    ST_MEMWAIT = 3'd3,
    ST_DECODE  = 3'd4,
    ST_EXEC    = 3'd5,
    ST_HALT    = 3'd6,
    ST_FAULT   = 3'd7
  } state_t;

  // PC mux select codes
  localparam int unsigned PC_SRC_INC    = 0;
  localparam int unsigned PC_SRC_BRANCH = 1;
  localparam int unsigned PC_SRC_VECTOR = 2;

  // Address mux select codes
  localparam int unsigned ADDR_SRC_PC = 0;
  localparam int unsigned ADDR_SRC_IR = 1;

  // Memory-wait counter width; saturates at all-ones.
  localparam int unsigned WAIT_CNT_W = 4;

  // All strobes are active-low; '1 is the idle value.
  typedef struct packed {
    logic pc_rst_n;
    logic mar_rst_n;
    logic pc_ld_n;
    logic mar_ld_n;
    logic ir_ld_n;
    logic mem_rd_n;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '1;

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Bundle between the fetch sequencer and the datapath / memory / execute stage.
//   Status into the sequencer : mem_rdy_i, exec_done_i, branch_i, halt_i
//   Strobes out (active-low)  : pc_rst_no, mar_rst_no, pc_ld_no, mar_ld_no,
//                               ir_ld_no, mem_rd_no
//   Selects out               : pc_src_o, addr_src_o
//   Debug / status out        : state_o, fault_o
// Modports: master = sequencer side, slave = datapath side.
//
// Handshake: mem_rd_no low is the read request and stays low for as long as
// the sequencer is waiting; mem_rdy_i high in any such cycle completes the
// read in that same cycle (ir_ld_no pulses low with it). exec_done_i high
// completes the execute phase in that cycle, and branch_i / halt_i are only
// meaningful in a cycle where exec_done_i is high. There is no back-pressure
// from the sequencer on either handshake.
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
  parameter int PC_SelectSize   = 3,
  parameter int ADDR_SelectSize = 2
);

  logic                       mem_rdy_i;
  logic                       exec_done_i;
  logic                       branch_i;
  logic                       halt_i;

  logic                       pc_rst_no;
  logic                       mar_rst_no;
  logic                       pc_ld_no;
  logic                       mar_ld_no;
  logic                       ir_ld_no;
  logic                       mem_rd_no;
  logic [PC_SelectSize-1:0]   pc_src_o;
  logic [ADDR_SelectSize-1:0] addr_src_o;
  logic [2:0]                 state_o;
  logic                       fault_o;

  modport master (
    input  mem_rdy_i, exec_done_i, branch_i, halt_i,
    output pc_rst_no, mar_rst_no, pc_ld_no, mar_ld_no, ir_ld_no, mem_rd_no,
    output pc_src_o, addr_src_o, state_o, fault_o
  );

  modport slave (
    output mem_rdy_i, exec_done_i, branch_i, halt_i,
    input  pc_rst_no, mar_rst_no, pc_ld_no, mar_ld_no, ir_ld_no, mem_rd_no,
    input  pc_src_o, addr_src_o, state_o, fault_o
  );

endinterface

// File: rtl/fetch_sequencer_wait_counter.sv
// -----------------------------------------------------------------------------
// wait_counter
// Memory-wait cycle counter, updated on the falling clock edge.
//   clk_i      : clock (falling edge active)
//   reset_ni   : asynchronous active-low reset, clears the count
//   clear_i    : synchronous clear (wins over enable)
//   enable_i   : count up by one; holds at all-ones instead of wrapping
//   terminal_o : count equals LIMIT-1, i.e. the last permitted wait cycle
// -----------------------------------------------------------------------------
module wait_counter
  import a09_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  localparam logic [WAIT_CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WAIT_CNT_W-1:0] CNT_TERM = WAIT_CNT_W'(LIMIT - 1);

  logic [WAIT_CNT_W-1:0] count_q;

  always_ff @(negedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != CNT_MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign terminal_o = (count_q == CNT_TERM);

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Control FSM for the fetch / decode / execute loop of a small CPU.
//   clk_i    : single clock, all state changes on the falling edge
//   reset_ni : asynchronous active-low reset -> RESET state, fault cleared
//   bus      : fetch_sequencer_if.master
//              in : mem_rdy_i, exec_done_i, branch_i, halt_i
//              out: active-low strobes, pc_src_o, addr_src_o,
//                   state_o (debug LEDs), fault_o (sticky timeout fault)
// Sequence: RESET -> VECTOR -> FETCH -> MEMWAIT -> DECODE -> EXEC -> FETCH ...
// with HALT and FAULT as absorbing states left only through reset.
// -----------------------------------------------------------------------------
module fetch_sequencer
  import a09_ctrl_pkg::*;
#(
  parameter int PC_SelectSize   = 3,
  parameter int ADDR_SelectSize = 2,
  parameter int MEM_TIMEOUT     = 15
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  fetch_sequencer_if.master   bus
);

  state_t                     state_q;
  state_t                     state_d;
  logic                       fault_q;
  logic                       cnt_clear;
  logic                       cnt_en;
  logic                       wait_term;
  strobes_t                   strb;
  logic [PC_SelectSize-1:0]   pc_src;
  logic [ADDR_SelectSize-1:0] addr_src;

  wait_counter #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_counter (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .clear_i    (cnt_clear),
    .enable_i   (cnt_en),
    .terminal_o (wait_term)
  );

  // State register. The fault flag is set on entry to FAULT; since FAULT
  // only exits through reset, it stays set until reset.
  always_ff @(negedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_RESET;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_q | (state_d == ST_FAULT);
    end
  end

  // Next-state logic and wait-counter control.
  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      ST_RESET:  state_d = ST_VECTOR;
      ST_VECTOR: state_d = ST_FETCH;
      ST_FETCH: begin
        state_d   = ST_MEMWAIT;
        cnt_clear = 1'b1;
      end
      ST_MEMWAIT: begin
        // Data arriving on the last permitted cycle still wins over timeout.
        if (bus.mem_rdy_i) begin
          state_d = ST_DECODE;
        end else begin
          cnt_en = 1'b1;
          if (wait_term) state_d = ST_FAULT;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (bus.exec_done_i) state_d = bus.halt_i ? ST_HALT : ST_FETCH;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_RESET;
    endcase
  end

  // Output logic. IR load in MEMWAIT and the branch load in EXEC depend on
  // the current inputs (Mealy); everything else follows the state alone.
  always_comb begin
    strb     = STROBES_IDLE;
    pc_src   = PC_SelectSize'(PC_SRC_INC);
    addr_src = ADDR_SelectSize'(ADDR_SRC_PC);
    case (state_q)
      ST_RESET: begin
        strb.pc_rst_n  = 1'b0;
        strb.mar_rst_n = 1'b0;
      end
      ST_VECTOR: begin
        pc_src       = PC_SelectSize'(PC_SRC_VECTOR);
        strb.pc_ld_n = 1'b0;
      end
      ST_FETCH: begin
        addr_src      = ADDR_SelectSize'(ADDR_SRC_PC);
        strb.mar_ld_n = 1'b0;
      end
      ST_MEMWAIT: begin
        strb.mem_rd_n = 1'b0;
        if (bus.mem_rdy_i) strb.ir_ld_n = 1'b0;
      end
      ST_DECODE: begin
        pc_src       = PC_SelectSize'(PC_SRC_INC);
        strb.pc_ld_n = 1'b0;
      end
      ST_EXEC: begin
        if (bus.exec_done_i && bus.branch_i) begin
          pc_src       = PC_SelectSize'(PC_SRC_BRANCH);
          strb.pc_ld_n = 1'b0;
        end
      end
      default: begin
        strb = STROBES_IDLE;
      end
    endcase
  end

  assign bus.pc_rst_no  = strb.pc_rst_n;
  assign bus.mar_rst_no = strb.mar_rst_n;
  assign bus.pc_ld_no   = strb.pc_ld_n;
  assign bus.mar_ld_no  = strb.mar_ld_n;
  assign bus.ir_ld_no   = strb.ir_ld_n;
  assign bus.mem_rd_no  = strb.mem_rd_n;
  assign bus.pc_src_o   = pc_src;
  assign bus.addr_src_o = addr_src;
  assign bus.state_o    = state_q;
  assign bus.fault_o    = fault_q;

endmodule
